sudoku_grid_decoder: RTL
========================

# sudoku_grid_decoder

Sequential read-out stage that sits after the combinational candidate-elimination stages of the sudoku checker. It accepts a 729-bit elimination mask and walks the 81 cells one per handshake, turning each cell's 9-bit candidate slice into a digit, a candidate count and a status. After the last cell it reports a puzzle summary. It is the consumer/decoder end of the mask format the elimination stages produce.

## Interface
- No parameters; geometry fixed at 9x9 with 9 values (constants in package).
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mask_in  in  729  elimination mask. Bit x*81+y*9+v set means value v+1 excluded for cell (x,y).
- mask_valid  in  1  mask_in valid.
- mask_ready  out  1  high only in IDLE.
- cell_valid  out  1  current cell output valid.
- cell_ready  in  1  downstream accepts the current cell.
- cell_x  out  4  cell column 0..8.
- cell_y  out  4  cell row 0..8.
- cell_digit  out  4  1..9 when SOLVED, else 0.
- cell_cand  out  4  remaining candidates 0..9, i.e. the count of zero bits.
- cell_status  out  2  00 OPEN, 01 SOLVED, 10 CONFLICT.
- done  out  1  one-cycle pulse after the last cell is accepted.
- solved_cnt  out  7  number of SOLVED cells in the last puzzle, 0..81.
- any_conflict  out  1  at least one CONFLICT cell in the last puzzle.

## Operation
- States are IDLE, STREAM and DONE.
- **IDLE:** mask_ready=1.
  - When mask_valid & mask_ready: latch mask_in into a 729-bit register.
  - Clear the cell index k, solved_cnt and any_conflict.
  - Go to STREAM.
- **STREAM:** cell_valid=1.
  - Cell mapping: k = x*9+y, so cell_x=k/9 and cell_y=k%9. Cells are visited in ascending bit order: x-major, then y.
  - The decode uses slice latched[k*9+8 : k*9].
  - cell_cand = 9 − popcount(slice).
  - cand=1 gives SOLVED, with digit = index of the single zero bit + 1.
  - cand=0 gives CONFLICT, digit 0.
  - cand≥2 gives OPEN, digit 0.
  - On cell_valid & cell_ready:
    - solved_cnt increments if the cell is SOLVED.
    - any_conflict sets if the cell is CONFLICT.
    - k increments.
    - If k was 80, go to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE.
  - solved_cnt and any_conflict hold their values until the next mask is accepted.
- mask_valid outside IDLE is ignored. The latched mask does not change during STREAM.
- Width rules:
  - popcount uses 4-bit arithmetic.
  - solved_cnt saturates naturally at 81, since there is no overflow path.
  - k is 7 bits.
- Reset (any time, including mid-stream):
  - State goes to IDLE and k=0.
  - The latched mask is cleared to all zeros.
  - Output values while reset is asserted: mask_ready=1, cell_valid=0, done=0, solved_cnt=0, any_conflict=0, cell_x/cell_y/cell_digit=0.
  - While reset is asserted, cell_cand and cell_status decode the cleared mask.

## Timing
- Mask accepted at edge T gives cell_valid=1 from cycle T+1, presenting cell (0,0).
- cell_* outputs are decoded combinationally from the registered k and the latched mask. They are stable while cell_valid=1 and cell_ready=0.
- cell_valid never drops mid-stream, and no cell is skipped or repeated.
- With cell_ready tied high, throughput is one cell per cycle. Cell 80 is accepted at T+81, and done is high in cycle T+82.
- mask_ready returns high in cycle T+83.
- Minimum interval between mask accepts is 83 cycles.
- solved_cnt/any_conflict are updated at the acceptance edge of each cell. Their final values are visible in the done cycle.

## Structure
- Package sudoku_pkg holds:
  - the constants N=9, CELLS=81, MASK_W=729;
  - the cell_status enum (OPEN, SOLVED, CONFLICT) and its 2-bit encoding;
  - a function for the mask bit index, x*81+y*9+v.
- Sub-module sudoku_cell_decode is purely combinational:
  - input: 9-bit slice;
  - outputs: digit, cand and status.
- The top level holds the FSM, the index counter, the mask register, the summary accumulators and a 729→9 slice mux.

## Test plan
- **All-zero mask, cell_ready=1:** 81 cells in order (0,0),(0,1)..(8,8), each OPEN with cand 9 and digit 0. done at T+82, solved_cnt=0, any_conflict=0.
- **Mask from a known complete valid grid (exactly 8 bits set per cell):** every cell SOLVED with digit equal to the grid value. solved_cnt=81, any_conflict=0.
- **Mask with cell (0,0) all 9 bits set and cell (4,4) bits 0..7 set, rest zero:**
  - First cell is CONFLICT with digit 0 and cand 0.
  - Cell k=40 is SOLVED with digit 9.
  - solved_cnt=1, any_conflict=1.
- **Backpressure:** hold cell_ready=0 for 5 cycles while k=40.
  - cell_x=4, cell_y=4 and all cell_* stay stable.
  - Next accepted cell is (4,5), and total accepted cells = 81.
- **mask_valid pulsed with a different mask during STREAM:** ignored, and the output stream matches the first mask. After done, mask_ready=1 and the second mask is accepted.
- **rst_n asserted at k=30:** immediately cell_valid=0 and mask_ready=1, with no done pulse. After release, a new mask streams from (0,0) with solved_cnt restarting at 0.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared geometry, status encoding and FSM states for the sudoku grid decoder.
// Mask bit x*81+y*9+v set means value v+1 is excluded for cell (x,y).
package sudoku_pkg;

    localparam int N      = 9;
    localparam int CELLS  = 81;
    localparam int MASK_W = 729;
    localparam int K_W    = 7;

    localparam logic [K_W-1:0] LAST_K = K_W'(CELLS - 1);

    typedef enum logic [1:0] {
        STATUS_OPEN     = 2'b00,
        STATUS_SOLVED   = 2'b01,
        STATUS_CONFLICT = 2'b10
    } cell_status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_STREAM = 2'b01,
        S_DONE   = 2'b10
    } fsm_state_e;

    function automatic int unsigned mask_bit_idx(input int unsigned x,
                                                 input int unsigned y,
                                                 input int unsigned v);
        return x * (N * N) + y * N + v;
    endfunction

endpackage

// File: rtl/sudoku_cell_decode.sv
// Combinational decode of one cell's 9-bit exclusion slice into candidate
// count, status and (when exactly one candidate remains) the digit.
module sudoku_cell_decode
    import sudoku_pkg::*;
(
    input  logic [N-1:0]  slice_i,
    output logic [3:0]    digit_o,
    output logic [3:0]    cand_o,
    output cell_status_e  status_o
);

    logic [3:0] excluded;
    logic [3:0] zero_idx;

    always_comb begin
        excluded = 4'd0;
        zero_idx = 4'd0;
        for (int i = 0; i < N; i++) begin
            excluded = excluded + {3'b000, slice_i[i]};
            // Only meaningful when a single zero exists; then it is unique.
            if (!slice_i[i]) begin
                zero_idx = 4'(i);
            end
        end
    end

    always_comb begin
        cand_o   = 4'd9 - excluded;
        digit_o  = 4'd0;
        status_o = STATUS_OPEN;
        if (cand_o == 4'd1) begin
            status_o = STATUS_SOLVED;
            digit_o  = zero_idx + 4'd1;
        end else if (cand_o == 4'd0) begin
            status_o = STATUS_CONFLICT;
        end
    end

endmodule

// File: rtl/sudoku_grid_decoder.sv
// Latches a 729-bit elimination mask and streams the 81 decoded cells one per
// handshake, then pulses done with the puzzle's solved count and conflict flag.
module sudoku_grid_decoder
    import sudoku_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MASK_W-1:0] mask_in,
    input  logic              mask_valid,
    output logic              mask_ready,
    output logic              cell_valid,
    input  logic              cell_ready,
    output logic [3:0]        cell_x,
    output logic [3:0]        cell_y,
    output logic [3:0]        cell_digit,
    output logic [3:0]        cell_cand,
    output logic [1:0]        cell_status,
    output logic              done,
    output logic [6:0]        solved_cnt,
    output logic              any_conflict
);

    fsm_state_e        state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [MASK_W-1:0] mask_q;
    logic [6:0]        solved_q, solved_d;
    logic              conflict_q, conflict_d;
    logic              load_mask;

    logic [N-1:0]      slices [CELLS];
    logic [N-1:0]      cur_slice;
    cell_status_e      cur_status;

    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_slice
            assign slices[gi] = mask_q[mask_bit_idx(gi / N, gi % N, 0) +: N];
        end
    endgenerate

    always_comb begin
        cur_slice = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (k_q == K_W'(i)) begin
                cur_slice = slices[i];
            end
        end
    end

    sudoku_cell_decode u_decode (
        .slice_i  (cur_slice),
        .digit_o  (cell_digit),
        .cand_o   (cell_cand),
        .status_o (cur_status)
    );

    assign cell_status  = cur_status;
    assign cell_x       = 4'(k_q / K_W'(N));
    assign cell_y       = 4'(k_q % K_W'(N));
    assign solved_cnt   = solved_q;
    assign any_conflict = conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            solved_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            solved_q   <= solved_d;
            conflict_q <= conflict_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (load_mask) begin
            mask_q <= mask_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        solved_d   = solved_q;
        conflict_d = conflict_q;
        load_mask  = 1'b0;
        mask_ready = 1'b0;
        cell_valid = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mask_ready = 1'b1;
                if (mask_valid) begin
                    load_mask  = 1'b1;
                    k_d        = '0;
                    solved_d   = '0;
                    conflict_d = 1'b0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                cell_valid = 1'b1;
                if (cell_ready) begin
                    if (cur_status == STATUS_SOLVED) begin
                        solved_d = solved_q + 7'd1;
                    end
                    if (cur_status == STATUS_CONFLICT) begin
                        conflict_d = 1'b1;
                    end
                    // Park the index back on cell 0 so idle outputs stay benign.
                    if (k_q == LAST_K) begin
                        k_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
